ksort_beat_tx: RTL and testbench

KSORT_BEAT_TX -- requirements
Module: ksort_beat_tx

---
 rtl/ksort_pkg.sv | 24 ++
 rtl/ksort_pair_store.sv | 57 +++++
 rtl/ksort_beat_tx.sv | 128 ++++++++++++
 tb/tb_ksort_beat_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ksort_pkg.sv
// Shared top-K beat transmitter definitions: default geometry and the FSM state encoding.
// The ALU side imports the same NBEATS so both ends agree on the beat count.
package ksort_pkg;

  localparam int          KSORT_K     = 20;
  localparam int          KSORT_LANES = 16;
  localparam logic [31:0] KSORT_PAD   = 32'hFFFF_FFFF;

  // The extra beat always exists, even when 2K divides LANES evenly, so the receiver's
  // completion count stays a fixed function of K.
  function automatic int ksort_nbeats(input int k, input int lanes);
    return (2 * k) / lanes + 1;
  endfunction

  localparam int KSORT_NBEATS = ksort_nbeats(KSORT_K, KSORT_LANES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : ksort_pkg

// File: rtl/ksort_pair_store.sv
// K-entry (data, index) register file with one write port and a flattened read view.
// The read view shows this cycle's write, so the first beat can be captured on the final load.
module ksort_pair_store
  import ksort_pkg::*;
#(
  parameter int          K   = KSORT_K,
  parameter int          IW  = 5,
  parameter logic [31:0] PAD = KSORT_PAD
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [31:0]       wr_data,
  input  logic [31:0]       wr_index,
  input  logic              wr_fill,
  output logic [2*K*32-1:0] flat
);

  logic [31:0] data_q  [K];
  logic [31:0] index_q [K];
  logic [31:0] data_nxt  [K];
  logic [31:0] index_nxt [K];

  always_comb begin
    // NOTE: every always_comb output takes a default before any condition, so no latch is inferred.
    for (int i = 0; i < K; i++) begin
      data_nxt[i]  = data_q[i];
      index_nxt[i] = index_q[i];
      if (wr_en) begin
        if (IW'(i) == wr_idx) begin
          data_nxt[i]  = wr_data;
          index_nxt[i] = wr_index;
        end else if (wr_fill && (IW'(i) > wr_idx)) begin
          data_nxt[i]  = PAD;
          index_nxt[i] = PAD;
        end
      end
    end
  end

  // NOTE: slot storage has no reset; every slot is written before a list is ever sent.
  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      data_q[i]  <= data_nxt[i];
      index_q[i] <= index_nxt[i];
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < K; i++) begin
      flat[i*32 +: 32]     = data_nxt[i];
      flat[(K+i)*32 +: 32] = index_nxt[i];
    end
  end

endmodule : ksort_pair_store

// File: rtl/ksort_beat_tx.sv
// Collects up to K (data, index) pairs, pads the rest, and streams the flattened list
// as NBEATS beats of LANES 32-bit words over a valid/ready handshake.
module ksort_beat_tx
  import ksort_pkg::*;
#(
  parameter int          K     = KSORT_K,
  parameter int          LANES = KSORT_LANES,
  parameter logic [31:0] PAD   = KSORT_PAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic [31:0]       ld_index,
  input  logic              ld_last,
  output logic [LANES*32-1:0] beat,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [31:0]       beat_count,
  output logic              beat_last,
  input  logic              abort,
  output logic              done
);

  localparam int NBEATS = ksort_nbeats(K, LANES);
  localparam int WORDS  = NBEATS * LANES;
  localparam int BW     = LANES * 32;
  localparam int CW     = (K > 1) ? $clog2(K) : 1;

  state_t              state;
  logic [CW-1:0]       ld_cnt;
  logic [2*K*32-1:0]   pair_flat;
  logic [WORDS*32-1:0] words;
  logic [31:0]         beat_sel;
  logic                ld_acc;
  logic                ld_end;
  logic                st_wr;
  logic                beat_hs;

  assign ld_ready  = (state == IDLE) || (state == LOAD);
  assign ld_acc    = ld_valid && ld_ready;
  assign ld_end    = ld_last || (ld_cnt == CW'(K - 1));
  assign st_wr     = ld_acc && !abort;
  assign beat_hs   = beat_valid && beat_ready;
  assign beat_last = (beat_count == 32'(NBEATS - 1));

  ksort_pair_store #(
    .K   (K),
    .IW  (CW),
    .PAD (PAD)
  ) u_store (
    .clk      (clk),
    .wr_en    (st_wr),
    .wr_idx   (ld_cnt),
    .wr_data  (ld_data),
    .wr_index (ld_index),
    .wr_fill  (ld_end),
    .flat     (pair_flat)
  );

  // Words past 2K are zero so every beat is fully defined.
  assign words = {{((WORDS - 2*K) * 32){1'b0}}, pair_flat};

  // Beat to capture on the coming edge: the next beat in SEND, beat 0 otherwise.
  always_comb begin
    beat_sel = 32'd0;
    if (state == SEND && beat_count < 32'(NBEATS - 1)) begin
      beat_sel = beat_count + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ld_cnt     <= '0;
      beat_count <= '0;
      beat_valid <= 1'b0;
      done       <= 1'b0;
      beat       <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        ld_cnt     <= '0;
        beat_count <= '0;
        beat_valid <= 1'b0;
      end else begin
        case (state)
          IDLE, LOAD: begin
            if (ld_acc) begin
              if (ld_end) begin
                state      <= SEND;
                ld_cnt     <= '0;
                beat_count <= '0;
                beat_valid <= 1'b1;
                beat       <= words[beat_sel*BW +: BW];
              end else begin
                state  <= LOAD;
                ld_cnt <= ld_cnt + 1'b1;
              end
            end
          end
          SEND: begin
            if (beat_hs) begin
              if (beat_last) begin
                state      <= DONE;
                done       <= 1'b1;
                beat_valid <= 1'b0;
                beat_count <= '0;
              end else begin
                beat_count <= beat_count + 32'd1;
                beat       <= words[beat_sel*BW +: BW];
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule : ksort_beat_tx

// File: tb/tb_ksort_beat_tx.sv
// Directed bench for ksort_beat_tx: full load, backpressure, short list, abort,
// mid-transfer reset and load attempts during SEND, all against hand-derived words.
module tb_ksort_beat_tx;

  localparam int K      = 20;
  localparam int LANES  = 16;
  localparam int NBEATS = 3;
  localparam logic [31:0] PAD = 32'hFFFF_FFFF;

  logic                clk = 1'b0;
  logic                rst;
  logic                ld_valid;
  logic                ld_ready;
  logic [31:0]         ld_data;
  logic [31:0]         ld_index;
  logic                ld_last;
  logic [LANES*32-1:0] beat;
  logic                beat_valid;
  logic                beat_ready;
  logic [31:0]         beat_count;
  logic                beat_last;
  logic                abort;
  logic                done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ksort_beat_tx #(.K(K), .LANES(LANES), .PAD(PAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_index   (ld_index),
    .ld_last    (ld_last),
    .beat       (beat),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_count (beat_count),
    .beat_last  (beat_last),
    .abort      (abort),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected flattened word for a list of n pairs data=dbase+i, index=ibase+i.
  function automatic logic [31:0] exp_word(input int w, input int n, input int dbase, input int ibase);
    if (w < K)       return (w < n) ? 32'(dbase + w) : PAD;
    if (w < 2 * K)   return ((w - K) < n) ? 32'(ibase + w - K) : PAD;
    return 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input int c, input int n, input int dbase, input int ibase);
    check($sformatf("%s_valid", tag), 32'(beat_valid), 32'd1);
    check($sformatf("%s_count", tag), beat_count, 32'(c));
    check($sformatf("%s_last", tag), 32'(beat_last), (c == NBEATS - 1) ? 32'd1 : 32'd0);
    for (int l = 0; l < LANES; l++) begin
      check($sformatf("%s_lane%0d", tag, l), beat[l*32 +: 32], exp_word(c * LANES + l, n, dbase, ibase));
    end
  endtask

  // Offers n pairs back to back; ld_last marks the final one only for short lists.
  task automatic load_list(input int n, input int dbase, input int ibase);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'(dbase + i);
      ld_index = 32'(ibase + i);
      ld_last  = (n < K) && (i == n - 1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic run_out(input string tag, input int n, input int dbase, input int ibase);
    for (int c = 0; c < NBEATS; c++) begin
      check_beat($sformatf("%s_b%0d", tag, c), c, n, dbase, ibase);
      tick();
    end
    check($sformatf("%s_done", tag), 32'(done), 32'd1);
    check($sformatf("%s_done_nv", tag), 32'(beat_valid), 32'd0);
    tick();
    check($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
    check($sformatf("%s_idle_rdy", tag), 32'(ld_ready), 32'd1);
    check($sformatf("%s_idle_cnt", tag), beat_count, 32'd0);
  endtask

  logic [LANES*32-1:0] held;

  initial begin
    rst = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_index = '0; ld_last = 1'b0;
    beat_ready = 1'b0; abort = 1'b0;
    #2;
    check("rst_valid", 32'(beat_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", beat_count, 32'd0);
    check("rst_beat_l0", beat[31:0], 32'd0);
    check("rst_beat_l15", beat[15*32 +: 32], 32'd0);
    #20 rst = 1'b1;
    tick();
    check("rst_ld_ready", 32'(ld_ready), 32'd1);

    // Full list, data=i, index=100+i, downstream always ready.
    beat_ready = 1'b1;
    load_list(20, 0, 100);
    check("full_b1_l4", 32'd100, exp_word(LANES + 4, 20, 0, 100));
    run_out("full", 20, 0, 100);

    // Backpressure during beat 1.
    beat_ready = 1'b1;
    load_list(20, 32'h1000, 32'h2000);
    check_beat("bp_b0", 0, 20, 32'h1000, 32'h2000);
    tick();
    beat_ready = 1'b0;
    held = beat;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(beat_valid), 32'd1);
      check("bp_hold_count", beat_count, 32'd1);
      check("bp_hold_l0", beat[31:0], held[31:0]);
      check("bp_hold_l9", beat[9*32 +: 32], held[9*32 +: 32]);
    end
    check_beat("bp_b1", 1, 20, 32'h1000, 32'h2000);
    beat_ready = 1'b1;
    tick();
    check_beat("bp_b2", 2, 20, 32'h1000, 32'h2000);
    tick();
    check("bp_done", 32'(done), 32'd1);
    tick();

    // Short list: ld_last on the third pair pads the remaining slots.
    load_list(3, 32'h50, 32'h60);
    check("short_b0_l3", beat[3*32 +: 32], PAD);
    run_out("short", 3, 32'h50, 32'h60);

    // Abort together with the beat-1 handshake.
    load_list(20, 200, 300);
    tick();
    check_beat("ab_b1", 1, 20, 200, 300);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", 32'(beat_valid), 32'd0);
    check("ab_ld_ready", 32'(ld_ready), 32'd1);
    check("ab_count", beat_count, 32'd0);
    check("ab_done", 32'(done), 32'd0);
    load_list(20, 400, 500);
    run_out("ab_reload", 20, 400, 500);

    // Reset pulse while beat 1 is offered.
    load_list(20, 600, 700);
    tick();
    check("rs_pre_count", beat_count, 32'd1);
    rst = 1'b0;
    #1;
    check("rs_valid", 32'(beat_valid), 32'd0);
    check("rs_count", beat_count, 32'd0);
    check("rs_beat_l0", beat[31:0], 32'd0);
    check("rs_done", 32'(done), 32'd0);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rs_quiet_valid", 32'(beat_valid), 32'd0);
      check("rs_quiet_rdy", 32'(ld_ready), 32'd1);
    end
    load_list(20, 800, 900);
    run_out("rs_reload", 20, 800, 900);

    // Load offered throughout SEND must be ignored.
    load_list(20, 1000, 1100);
    beat_ready = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hDEAD; ld_index = 32'hBEEF; ld_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ls_ld_ready", 32'(ld_ready), 32'd0);
      check("ls_count", beat_count, 32'd0);
    end
    beat_ready = 1'b1;
    for (int c = 0; c < NBEATS; c++) begin
      check_beat($sformatf("ls_b%0d", c), c, 20, 1000, 1100);
      tick();
    end
    check("ls_done", 32'(done), 32'd1);
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    check("ls_end_valid", 32'(beat_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ksort_beat_tx
